mmio_ledsw: RTL and testbench

MMIO_LEDSW -- requirements
Module: mmio_ledsw

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/sw_debounce.sv | 77 +++++++
 rtl/mmio_ledsw.sv | 92 +++++++++
 tb/tb_mmio_ledsw.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped LED/switch peripheral:
// bus widths, default register addresses and the debounce state encoding.
package mmio_pkg;

    localparam int unsigned SW_W   = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] DEF_ADDR_LED  = 16'hC000;
    localparam logic [ADDR_W-1:0] DEF_ADDR_SW   = 16'hC001;
    localparam logic [ADDR_W-1:0] DEF_ADDR_STAT = 16'hC002;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_e;

    // Zero-extend a switch/LED-wide value onto the data bus.
    function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] v);
        return {{(DATA_W - SW_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a debounce FSM that only accepts a switch
// pattern after DEBOUNCE_CYCLES consecutive identical synchronized samples.
module sw_debounce
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_stable,
    output logic            chg_pulse
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync_meta_q;
    logic [SW_W-1:0]  sync_q;
    db_state_e        state_q;
    logic [SW_W-1:0]  cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW_W-1:0]  sw_stable_q;
    logic             chg_pulse_q;

    // Metastability guard: raw board switches are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= sw_raw;
            sync_q      <= sync_meta_q;
        end
    end

    // Any disagreement with the candidate restarts the count; a return to the
    // accepted value is treated as a glitch and abandons the candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STABLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            sw_stable_q <= '0;
            chg_pulse_q <= 1'b0;
        end else begin
            chg_pulse_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (sync_q != sw_stable_q) begin
                        state_q <= SETTLING;
                        cand_q  <= sync_q;
                        cnt_q   <= '0;
                    end
                end
                SETTLING: begin
                    if (sync_q == sw_stable_q) begin
                        state_q <= STABLE;
                    end else if (sync_q != cand_q) begin
                        cand_q <= sync_q;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        sw_stable_q <= cand_q;
                        chg_pulse_q <= 1'b1;
                        state_q     <= STABLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign sw_stable = sw_stable_q;
    assign chg_pulse = chg_pulse_q;

endmodule

// File: rtl/mmio_ledsw.sv
// Memory-mapped board I/O: a writable LED register, a debounced switch read
// port and a sticky switch-change flag that is cleared by reading it.
module mmio_ledsw
    import mmio_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter logic [ADDR_W-1:0] ADDR_LED        = DEF_ADDR_LED,
    parameter logic [ADDR_W-1:0] ADDR_SW         = DEF_ADDR_SW,
    parameter logic [ADDR_W-1:0] ADDR_STAT       = DEF_ADDR_STAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic [SW_W-1:0]   SW_in,
    output logic [SW_W-1:0]   LEDR_out,
    output logic              sw_chg
);

    logic [SW_W-1:0]   sw_stable;
    logic              chg_pulse;
    logic [SW_W-1:0]   led_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              sw_chg_q;
    logic              wr_led_c;
    logic              rd_stat_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              unused_wdata_hi;

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (SW_in),
        .sw_stable (sw_stable),
        .chg_pulse (chg_pulse)
    );

    // Only the LED-wide low bits of a store are meaningful.
    assign unused_wdata_hi = ^wdata[DATA_W-1:SW_W];

    assign wr_led_c  = we && (addr == ADDR_LED);
    assign rd_stat_c = re && (addr == ADDR_STAT);

    // Read mux sees pre-edge register values, so a same-cycle store or flag
    // clear is not reflected in the data returned.
    always_comb begin
        rd_data_c = '0;
        if (addr == ADDR_SW) begin
            rd_data_c = zext_sw(sw_stable);
        end else if (addr == ADDR_LED) begin
            rd_data_c = zext_sw(led_q);
        end else if (addr == ADDR_STAT) begin
            rd_data_c = {{(DATA_W - 1){1'b0}}, sw_chg_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            sw_chg_q <= 1'b0;
        end else begin
            rvalid_q <= re;
            if (wr_led_c) begin
                led_q <= wdata[SW_W-1:0];
            end
            if (re) begin
                rdata_q <= rd_data_c;
            end
            // A new change event outranks a concurrent read-to-clear.
            if (chg_pulse) begin
                sw_chg_q <= 1'b1;
            end else if (rd_stat_c) begin
                sw_chg_q <= 1'b0;
            end
        end
    end

    assign LEDR_out = led_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign sw_chg   = sw_chg_q;

endmodule

// File: tb/tb_mmio_ledsw.sv
// Directed bench for mmio_ledsw: debounce latency, glitch rejection, LED
// stores, read timing, sticky-flag clear/set priority and mid-settle reset.
module tb_mmio_ledsw;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic        rvalid;
    logic [9:0]  sw_in;
    logic [9:0]  ledr;
    logic        sw_chg;

    int total = 0;
    int bad   = 0;
    int glitch = 0;

    mmio_ledsw #(
        .DEBOUNCE_CYCLES (16),
        .ADDR_LED        (16'hC000),
        .ADDR_SW         (16'hC001),
        .ADDR_STAT       (16'hC002)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .SW_in    (sw_in),
        .LEDR_out (ledr),
        .sw_chg   (sw_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] stable16();
        return {6'b0, dut.u_deb.sw_stable};
    endfunction

    initial begin
        rst_n = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        we    = 1'b0;
        re    = 1'b0;
        sw_in = 10'h000;
        #12;
        chk("rst_led",    {6'b0, ledr}, 16'h0000);
        chk("rst_rdata",  rdata,        16'h0000);
        chk("rst_rvalid", {15'b0, rvalid}, 16'h0000);
        chk("rst_chg",    {15'b0, sw_chg}, 16'h0000);
        #10;
        rst_n = 1'b1;
        step();

        // Switch bouncing faster than the debounce window must never be accepted.
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) sw_in = sw_in ^ 10'h001;
            step();
            if (dut.u_deb.sw_stable !== 10'h000 || sw_chg !== 1'b0) glitch++;
        end
        sw_in = 10'h000;
        repeat (20) step();
        chk("bounce_glitches", 16'(glitch), 16'h0000);
        chk("bounce_stable",   stable16(),  16'h0000);
        chk("bounce_chg",      {15'b0, sw_chg}, 16'h0000);

        // Clean change: sampled at edge 1, accepted on edge 19 (16 + 3).
        sw_in = 10'h1AA;
        repeat (18) step();
        chk("lat_edge18_stable", stable16(), 16'h0000);
        step();
        chk("lat_edge19_stable", stable16(), 16'h01AA);
        chk("lat_edge19_chg",    {15'b0, sw_chg}, 16'h0000);
        step();
        chk("lat_flag_set",      {15'b0, sw_chg}, 16'h0001);

        // Switch read, then rdata must hold once rvalid drops.
        addr = 16'hC001; re = 1'b1;
        step();
        re = 1'b0;
        chk("rd_sw_valid", {15'b0, rvalid}, 16'h0001);
        chk("rd_sw_data",  rdata, 16'h01AA);
        step();
        chk("rd_sw_valid_drop", {15'b0, rvalid}, 16'h0000);
        chk("rd_sw_hold",       rdata, 16'h01AA);

        // Back-to-back status reads: first returns the flag and clears it.
        addr = 16'hC002; re = 1'b1;
        step();
        chk("stat1_valid", {15'b0, rvalid}, 16'h0001);
        chk("stat1_data",  rdata, 16'h0001);
        step();
        re = 1'b0;
        chk("stat2_valid", {15'b0, rvalid}, 16'h0001);
        chk("stat2_data",  rdata, 16'h0000);
        step();
        chk("stat_valid_drop", {15'b0, rvalid}, 16'h0000);
        chk("stat_cleared",    {15'b0, sw_chg}, 16'h0000);

        // LED stores: upper data bits dropped, foreign address ignored.
        addr = 16'hC000; wdata = 16'hFFFF; we = 1'b1;
        step();
        we = 1'b0;
        chk("led_write", {6'b0, ledr}, 16'h03FF);
        addr = 16'hC005; wdata = 16'h0000; we = 1'b1;
        step();
        we = 1'b0;
        chk("led_other_addr", {6'b0, ledr}, 16'h03FF);
        addr = 16'hC000; re = 1'b1;
        step();
        re = 1'b0;
        chk("rd_led_data", rdata, 16'h03FF);
        addr = 16'hC123; re = 1'b1;
        step();
        re = 1'b0;
        chk("rd_unmapped_valid", {15'b0, rvalid}, 16'h0001);
        chk("rd_unmapped_data",  rdata, 16'h0000);

        // Simultaneous store and load to the LED register.
        addr = 16'hC000; wdata = 16'h0055; we = 1'b1;
        step();
        wdata = 16'h00AA; re = 1'b1;
        step();
        we = 1'b0; re = 1'b0;
        chk("wr_rd_old_data", rdata, 16'h0055);
        chk("wr_rd_valid",    {15'b0, rvalid}, 16'h0001);
        chk("wr_rd_new_led",  {6'b0, ledr}, 16'h00AA);

        // Status read on the same edge the flag is being set: set wins.
        sw_in = 10'h2F0;
        repeat (19) step();
        chk("collide_pre_stable", stable16(), 16'h02F0);
        addr = 16'hC002; re = 1'b1;
        step();
        re = 1'b0;
        chk("collide_rdata", rdata, 16'h0000);
        chk("collide_flag",  {15'b0, sw_chg}, 16'h0001);

        // Reset while settling with cnt=8, with a live read in flight.
        sw_in = 10'h3C3;
        repeat (10) step();
        addr = 16'hC000; re = 1'b1;
        step();
        re = 1'b0;
        chk("mid_cnt",    16'(dut.u_deb.cnt_q), 16'h0008);
        chk("mid_rvalid", {15'b0, rvalid}, 16'h0001);
        chk("mid_rdata",  rdata, 16'h00AA);
        rst_n = 1'b0;
        #1;
        chk("arst_led",    {6'b0, ledr}, 16'h0000);
        chk("arst_rdata",  rdata, 16'h0000);
        chk("arst_rvalid", {15'b0, rvalid}, 16'h0000);
        chk("arst_chg",    {15'b0, sw_chg}, 16'h0000);
        chk("arst_stable", stable16(), 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (18) step();
        chk("rearm_edge18_stable", stable16(), 16'h0000);
        chk("rearm_edge18_chg",    {15'b0, sw_chg}, 16'h0000);
        step();
        chk("rearm_edge19_stable", stable16(), 16'h03C3);
        step();
        chk("rearm_flag", {15'b0, sw_chg}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
